// File: rtl/seq_code_lock.sv
`default_nettype none
// ============================================================================
// Module      : seq_code_lock
// Description : Sequential digit code lock. Digits are entered one per
//               digit_valid strobe and compared with the active code only
//               after a full-length entry. A correct code opens the lock for
//               a fixed time. While open, the code can be reprogrammed.
//               Repeated wrong codes force a timed lockout with an alarm.
//               A partial entry that goes idle is abandoned without being
//               counted as a failure.
//
// Ports       : clk         - single clock, rising edge
//               rst_n       - synchronous active-low reset
//               digit_valid - one digit accepted per high cycle
//               digit       - digit value, sampled with digit_valid
//               prog_en     - reprogramming request (honoured while open)
//               unlock      - lock open (registered)
//               alarm       - lockout in progress (registered)
//               fail_cnt    - consecutive failed attempts (saturating)
//               prog_busy   - new code being collected (registered)
//
// Revision    : 1.0 - initial release
// ============================================================================
module seq_code_lock #(
    parameter int                            DIGIT_W     = 4,
    parameter int                            CODE_LEN    = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0]   RESET_CODE  = 16'h1234,
    parameter int                            MAX_FAIL    = 3,
    parameter int                            UNLOCK_CYC  = 8,
    parameter int                            LOCKOUT_CYC = 16,
    parameter int                            TIMEOUT_CYC = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              digit_valid,
    input  logic [DIGIT_W-1:0]                digit,
    input  logic                              prog_en,
    output logic                              unlock,
    output logic                              alarm,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt,
    output logic                              prog_busy
);

    localparam int c_CODE_W  = DIGIT_W * CODE_LEN;
    localparam int c_IDX_W   = $clog2(CODE_LEN);
    localparam int c_FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int c_TMR_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int c_CNT_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(CODE_LEN - 1);
    localparam logic [c_FAIL_W-1:0] c_FAIL_MAX  = c_FAIL_W'(MAX_FAIL);
    localparam logic [c_TMR_W-1:0]  c_TMR_LAST  = c_TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_OPEN_LAST = c_CNT_W'(UNLOCK_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_LOCK_LAST = c_CNT_W'(LOCKOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_PROG    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_mismatch;
    logic [c_FAIL_W-1:0]   r_fail_cnt;
    logic [c_CODE_W-1:0]   r_code;
    logic [c_CODE_W-1:0]   r_shadow;
    logic [c_TMR_W-1:0]    r_timer;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_unlock;
    logic                  r_alarm;
    logic                  r_prog_busy;

    // ------------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------------
    state_t                w_state_nxt;
    logic [c_IDX_W-1:0]    w_idx_nxt;
    logic                  w_mismatch_nxt;
    logic [c_FAIL_W-1:0]   w_fail_nxt;
    logic [c_CODE_W-1:0]   w_code_nxt;
    logic [c_CODE_W-1:0]   w_shadow_nxt;
    logic [c_TMR_W-1:0]    w_timer_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;

    logic [DIGIT_W-1:0]    w_code_fld [CODE_LEN];
    logic                  w_last_digit;
    logic                  w_mismatch_now;
    logic                  w_timeout;
    logic [c_FAIL_W-1:0]   w_fail_inc;
    logic [c_CODE_W-1:0]   w_shadow_shift;

    // Split the active code into digit fields; the first entered digit
    // lives in the most significant field.
    genvar g;
    generate
        for (g = 0; g < CODE_LEN; g = g + 1) begin : g_code_fld
            assign w_code_fld[g] = r_code[(CODE_LEN-1-g)*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    assign w_last_digit   = (r_idx == c_IDX_LAST);
    // Sticky: one wrong digit anywhere poisons the whole attempt, but the
    // verdict is only taken on the final digit.
    assign w_mismatch_now = r_mismatch | (digit != w_code_fld[r_idx]);
    // The idle timer only runs once a partial entry exists.
    assign w_timeout      = (r_idx != '0) && (r_timer == c_TMR_LAST);
    assign w_fail_inc     = (r_fail_cnt >= c_FAIL_MAX) ? c_FAIL_MAX
                                                       : r_fail_cnt + c_FAIL_W'(1);
    // Shift-in keeps the first programmed digit in the top field.
    assign w_shadow_shift = {r_shadow[c_CODE_W-DIGIT_W-1:0], digit};

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_mismatch_nxt = r_mismatch;
        w_fail_nxt     = r_fail_cnt;
        w_code_nxt     = r_code;
        w_shadow_nxt   = r_shadow;
        w_timer_nxt    = r_timer;
        w_cnt_nxt      = r_cnt;

        case (r_state)
            ST_ENTRY: begin
                if (digit_valid) begin
                    // A digit in the expiry cycle wins over the timeout.
                    w_timer_nxt = '0;
                    if (w_last_digit) begin
                        w_idx_nxt      = '0;
                        w_mismatch_nxt = 1'b0;
                        w_cnt_nxt      = '0;
                        if (!w_mismatch_now) begin
                            w_state_nxt = ST_OPEN;
                            w_fail_nxt  = '0;
                        end else if (w_fail_inc >= c_FAIL_MAX) begin
                            w_state_nxt = ST_LOCKOUT;
                            w_fail_nxt  = c_FAIL_MAX;
                        end else begin
                            w_fail_nxt  = w_fail_inc;
                        end
                    end else begin
                        w_idx_nxt      = r_idx + c_IDX_W'(1);
                        w_mismatch_nxt = w_mismatch_now;
                    end
                end else if (w_timeout) begin
                    w_idx_nxt      = '0;
                    w_mismatch_nxt = 1'b0;
                    w_timer_nxt    = '0;
                end else if (r_idx != '0) begin
                    w_timer_nxt = r_timer + c_TMR_W'(1);
                end
            end

            ST_OPEN: begin
                // Reprogramming takes priority, even in the final open cycle.
                if (prog_en) begin
                    w_state_nxt  = ST_PROG;
                    w_idx_nxt    = '0;
                    w_timer_nxt  = '0;
                    w_shadow_nxt = '0;
                end else if (r_cnt == c_OPEN_LAST) begin
                    w_state_nxt    = ST_ENTRY;
                    w_idx_nxt      = '0;
                    w_mismatch_nxt = 1'b0;
                    w_timer_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end

            ST_PROG: begin
                if (digit_valid) begin
                    w_timer_nxt  = '0;
                    w_shadow_nxt = w_shadow_shift;
                    if (w_last_digit) begin
                        w_code_nxt  = w_shadow_shift;
                        w_state_nxt = ST_ENTRY;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                    end
                end else if (w_timeout) begin
                    // Abandoned programming: old code stays in force.
                    w_state_nxt  = ST_ENTRY;
                    w_idx_nxt    = '0;
                    w_timer_nxt  = '0;
                    w_shadow_nxt = '0;
                end else if (r_idx != '0) begin
                    w_timer_nxt = r_timer + c_TMR_W'(1);
                end
            end

            ST_LOCKOUT: begin
                if (r_cnt == c_LOCK_LAST) begin
                    w_state_nxt    = ST_ENTRY;
                    w_fail_nxt     = '0;
                    w_idx_nxt      = '0;
                    w_mismatch_nxt = 1'b0;
                    w_timer_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_ENTRY;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register. Outputs are decoded from the next state so they are
    // registered yet line up with the state they describe; since they come
    // from one encoded state, unlock and alarm can never coincide.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_ENTRY;
            r_idx       <= '0;
            r_mismatch  <= 1'b0;
            r_fail_cnt  <= '0;
            r_code      <= RESET_CODE;
            r_shadow    <= '0;
            r_timer     <= '0;
            r_cnt       <= '0;
            r_unlock    <= 1'b0;
            r_alarm     <= 1'b0;
            r_prog_busy <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_mismatch  <= w_mismatch_nxt;
            r_fail_cnt  <= w_fail_nxt;
            r_code      <= w_code_nxt;
            r_shadow    <= w_shadow_nxt;
            r_timer     <= w_timer_nxt;
            r_cnt       <= w_cnt_nxt;
            r_unlock    <= (w_state_nxt == ST_OPEN);
            r_alarm     <= (w_state_nxt == ST_LOCKOUT);
            r_prog_busy <= (w_state_nxt == ST_PROG);
        end
    end

    assign unlock    = r_unlock;
    assign alarm     = r_alarm;
    assign fail_cnt  = r_fail_cnt;
    assign prog_busy = r_prog_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_code_lock.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_code_lock
// Description : Directed testbench for seq_code_lock with default parameters.
//               Each cycle pushes the expected outputs into a scoreboard
//               queue as stimulus is applied; after the clock edge the entry
//               is popped and compared against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_code_lock;

    logic       clk;
    logic       rst_n;
    logic       digit_valid;
    logic [3:0] digit;
    logic       prog_en;
    logic       unlock;
    logic       alarm;
    logic [1:0] fail_cnt;
    logic       prog_busy;

    seq_code_lock dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_valid (digit_valid),
        .digit       (digit),
        .prog_en     (prog_en),
        .unlock      (unlock),
        .alarm       (alarm),
        .fail_cnt    (fail_cnt),
        .prog_busy   (prog_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       u;
        logic       a;
        logic       b;
        logic [1:0] f;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    int    checks   = 0;
    int    failures = 0;

    // Current expected outputs after the next edge, maintained by the script.
    logic       exp_u;
    logic       exp_a;
    logic       exp_b;
    logic [1:0] exp_f;
    string      cur_tag;

    task automatic check_out();
        exp_t  e;
        exp_t  o;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        o = '{u: unlock, a: alarm, b: prog_busy, f: fail_cnt};
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed u/a/b/f=%b/%b/%b/%0d expected=%b/%b/%b/%0d",
                   t, o.u, o.a, o.b, o.f, e.u, e.a, e.b, e.f);
        end
        checks++;
        assert (!(unlock === 1'b1 && alarm === 1'b1)) else begin
            failures++;
            $error("FAIL %s_excl: observed unlock=%b alarm=%b expected not both 1",
                   t, unlock, alarm);
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] d, input logic p);
        digit_valid = v;
        digit       = d;
        prog_en     = p;
        sb_q.push_back('{u: exp_u, a: exp_a, b: exp_b, f: exp_f});
        tag_q.push_back(cur_tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0);
    endtask

    // Four-digit attempt; the outcome expectations apply from the last digit.
    task automatic attempt(input logic [15:0] c, input logic u, input logic a,
                           input logic [1:0] f);
        for (int i = 0; i < 3; i++) cyc(1'b1, c[15-4*i -: 4], 1'b0);
        exp_u = u;
        exp_a = a;
        exp_f = f;
        cyc(1'b1, c[3:0], 1'b0);
    endtask

    // Called right after the unlocking edge: 7 more open cycles, then closed.
    task automatic open_wait();
        exp_u = 1'b1;
        idle(7);
        exp_u = 1'b0;
        idle(1);
    endtask

    initial begin
        rst_n       = 1'b0;
        digit_valid = 1'b0;
        digit       = 4'h0;
        prog_en     = 1'b0;
        exp_u = 1'b0; exp_a = 1'b0; exp_b = 1'b0; exp_f = 2'd0;

        cur_tag = "reset";
        idle(2);
        rst_n = 1'b1;
        cur_tag = "post_reset";
        idle(1);

        // Correct code opens for 8 cycles; digits while open are ignored.
        cur_tag = "unlock";
        attempt(16'h1234, 1'b1, 1'b0, 2'd0);
        cur_tag = "open_hold";
        cyc(1'b1, 4'h1, 1'b0);
        cyc(1'b1, 4'h2, 1'b0);
        cyc(1'b1, 4'h3, 1'b0);
        cyc(1'b1, 4'h4, 1'b0);
        idle(3);
        cur_tag = "open_end";
        exp_u = 1'b0;
        idle(1);

        // Three failures (one with an early wrong digit) -> lockout.
        cur_tag = "fail1";
        attempt(16'h1235, 1'b0, 1'b0, 2'd1);
        cur_tag = "fail2_early";
        attempt(16'h5234, 1'b0, 1'b0, 2'd2);
        cur_tag = "fail3_lock";
        attempt(16'h1235, 1'b0, 1'b1, 2'd3);
        cur_tag = "lockout";
        cyc(1'b1, 4'h1, 1'b1);
        cyc(1'b1, 4'h2, 1'b1);
        cyc(1'b1, 4'h3, 1'b1);
        cyc(1'b1, 4'h4, 1'b1);
        for (int i = 0; i < 11; i++) cyc(1'b0, 4'h0, 1'b1);
        cur_tag = "lockout_end";
        exp_a = 1'b0;
        exp_f = 2'd0;
        idle(1);
        cur_tag = "post_lock_unlock";
        attempt(16'h1234, 1'b1, 1'b0, 2'd0);
        open_wait();

        // Idle timeout abandons a partial entry without counting a failure.
        cur_tag = "to_fail";
        attempt(16'h1235, 1'b0, 1'b0, 2'd1);
        cur_tag = "to_partial";
        cyc(1'b1, 4'h1, 1'b0);
        cyc(1'b1, 4'h2, 1'b0);
        idle(32);
        cur_tag = "to_unlock";
        attempt(16'h1234, 1'b1, 1'b0, 2'd0);
        open_wait();

        // Digit arriving in the expiry cycle is accepted; timer restarts.
        cur_tag = "expiry_digit";
        cyc(1'b1, 4'h1, 1'b0);
        idle(31);
        cyc(1'b1, 4'h2, 1'b0);
        idle(31);
        cyc(1'b1, 4'h3, 1'b0);
        cur_tag = "expiry_unlock";
        exp_u = 1'b1;
        cyc(1'b1, 4'h4, 1'b0);
        open_wait();

        // One idle cycle too many: the leading 1 is discarded.
        cur_tag = "expired";
        cyc(1'b1, 4'h1, 1'b0);
        idle(32);
        cyc(1'b1, 4'h2, 1'b0);
        cyc(1'b1, 4'h3, 1'b0);
        cyc(1'b1, 4'h4, 1'b0);
        idle(32);

        // Reprogram to 9876.
        cur_tag = "prog_unlock";
        attempt(16'h1234, 1'b1, 1'b0, 2'd0);
        cur_tag = "prog_busy";
        exp_u = 1'b0;
        exp_b = 1'b1;
        cyc(1'b0, 4'h0, 1'b1);
        cyc(1'b1, 4'h9, 1'b0);
        cyc(1'b1, 4'h8, 1'b0);
        cyc(1'b1, 4'h7, 1'b0);
        cur_tag = "prog_done";
        exp_b = 1'b0;
        cyc(1'b1, 4'h6, 1'b0);
        cur_tag = "old_code_fails";
        attempt(16'h1234, 1'b0, 1'b0, 2'd1);
        cur_tag = "new_code_unlocks";
        attempt(16'h9876, 1'b1, 1'b0, 2'd0);

        // Programming abandoned by timeout keeps 9876.
        cur_tag = "prog_to_open";
        idle(2);
        cur_tag = "prog_to_busy";
        exp_u = 1'b0;
        exp_b = 1'b1;
        cyc(1'b0, 4'h0, 1'b1);
        cyc(1'b1, 4'h7, 1'b0);
        cyc(1'b1, 4'h7, 1'b0);
        idle(31);
        cur_tag = "prog_to_expire";
        exp_b = 1'b0;
        idle(1);
        cur_tag = "prog_to_old_fails";
        attempt(16'h1234, 1'b0, 1'b0, 2'd1);
        cur_tag = "prog_to_kept";
        attempt(16'h9876, 1'b1, 1'b0, 2'd0);

        // Reset mid-programming reverts to the reset code.
        cur_tag = "rst_prog_open";
        idle(1);
        cur_tag = "rst_prog_busy";
        exp_u = 1'b0;
        exp_b = 1'b1;
        cyc(1'b0, 4'h0, 1'b1);
        cyc(1'b1, 4'h5, 1'b0);
        cyc(1'b1, 4'h5, 1'b0);
        cur_tag = "rst_prog";
        rst_n = 1'b0;
        exp_b = 1'b0;
        cyc(1'b0, 4'h0, 1'b0);
        rst_n = 1'b1;
        cur_tag = "rst_lost_code";
        attempt(16'h9876, 1'b0, 1'b0, 2'd1);
        cur_tag = "rst_reset_code";
        attempt(16'h1234, 1'b1, 1'b0, 2'd0);
        open_wait();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
